// File: rtl/wb_arbiter2_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // All inputs of one master, bundled so the owner mux is a single select.
    typedef struct packed {
        logic                cyc;
        logic                stb;
        logic                we;
        logic [WB_SEL_W-1:0] sel;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter2_pick.sv
// Combinational round-robin picker: on a tie the master not granted last time wins.
module wb_arb_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Pick a requester; a tie goes to the master that did not win last.
    always_comb begin
        gnt_valid = 1'b1;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: begin
                gnt_valid = 1'b0;
                gnt_idx   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter, round-robin, locked for the whole bus cycle.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that terminates stb-without-ack cycles.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    input  logic                s_ack_i,
    input  logic [WB_DAT_W-1:0] s_dat_i
);

    arb_state_t state_r, state_n;
    logic       owner_r, owner_n;
    logic       last_r, last_n;
    logic       gnt_valid_s, gnt_idx_s;
    logic       busy_s, timeout_s;
    wb_req_t    req0_s, req1_s, own_s;

    assign req0_s = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
    assign req1_s = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
    assign busy_s = (state_r == BUSY);

    wb_arb_pick u_pick (
        .req       ({m1_cyc_i, m0_cyc_i}),
        .last      (last_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Owner input mux.
    always_comb begin
        if (owner_r) begin
            own_s = req1_s;
        end else begin
            own_s = req0_s;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WDG_W = $clog2(TIMEOUT_CYCLES);
    logic [WDG_W-1:0] wdg_cnt_r;

    assign timeout_s = busy_s & own_s.stb & ~s_ack_i &
                       (wdg_cnt_r == WDG_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts consecutive owner-strobe cycles without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdg_cnt_r <= '0;
        end else if (!busy_s || s_ack_i || !own_s.stb || timeout_s) begin
            wdg_cnt_r <= '0;
        end else begin
            wdg_cnt_r <= wdg_cnt_r + WDG_W'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state: grant in IDLE, release when the owner drops cyc or the watchdog fires.
    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        last_n  = last_r;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    state_n = BUSY;
                    owner_n = gnt_idx_s;
                    last_n  = gnt_idx_s;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                if (!own_s.cyc || timeout_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = BUSY;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, owner and round-robin history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            last_r  <= last_n;
        end
    end

    // Slave side carries the owner's request only while BUSY.
    always_comb begin
        s_cyc_o = busy_s & own_s.cyc & ~timeout_s;
        s_stb_o = busy_s & own_s.stb & ~timeout_s;
        s_we_o  = busy_s & own_s.we;
        if (busy_s) begin
            s_sel_o = own_s.sel;
            s_adr_o = own_s.adr;
            s_dat_o = own_s.dat;
        end else begin
            s_sel_o = '0;
            s_adr_o = '0;
            s_dat_o = '0;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & busy_s & ~owner_r & own_s.stb;
    assign m1_ack_o = s_ack_i & busy_s &  owner_r & own_s.stb;
    assign m0_err_o = timeout_s & ~owner_r;
    assign m1_err_o = timeout_s &  owner_r;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed plus randomized bench for wb_arbiter2 against a rule-based arbitration model.
module tb_wb_arbiter2;

    logic        clk, rst;
    logic [1:0]  mcyc, mstb, mwe;
    logic [3:0]  msel [2];
    logic [29:0] madr [2];
    logic [31:0] mdat [2];
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [29:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_ack;
    logic [31:0] s_dat;

    int n_assert = 0;
    int n_fail   = 0;

    wb_arbiter2 #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_sel_i(msel[0]),
        .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_sel_i(msel[1]),
        .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack), .s_dat_i(s_dat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int n, input logic c, input logic s, input logic w,
                         input logic [3:0] sel, input logic [29:0] adr, input logic [31:0] dat);
        mcyc[n] = c; mstb[n] = s; mwe[n] = w;
        msel[n] = sel; madr[n] = adr; mdat[n] = dat;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        s_ack = 1'b0;
        s_dat = 32'h0;
        nxt();
        rst = 1'b0;
    endtask

    // random-phase model state
    int m_owner, m_last, m_wait, pick;
    int gap [2];
    bit act [2], acked [2], exp_ack [2];
    int done_cnt [2], dut_cnt [2];
    bit busy;

    initial begin
        do_reset();
        nxt();
        neg();
        chk("rst_s_cyc", s_cyc_o, 1'b0);
        chk("rst_s_stb", s_stb_o, 1'b0);
        chk("rst_s_adr", s_adr_o, 30'h0);
        chk("rst_acks", {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, 4'h0);

        // single m0 read
        nxt();
        set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h00100000, 32'h0);
        neg();
        chk("rd_arb_gap", s_cyc_o, 1'b0);
        nxt();
        s_ack = 1'b1; s_dat = 32'hDEADBEEF;
        neg();
        chk("rd_s_adr", s_adr_o, 30'h00100000);
        chk("rd_s_cyc", s_cyc_o, 1'b1);
        chk("rd_m0_ack", m0_ack_o, 1'b1);
        chk("rd_m1_ack", m1_ack_o, 1'b0);
        chk("rd_m0_dat", m0_dat_o, 32'hDEADBEEF);
        nxt();
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        neg();
        chk("rd_release", s_cyc_o, 1'b0);

        // contention from reset: expect 0,1,0,1
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h00000A00, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 30'h00000B00, 32'h0);
        neg();
        chk("ct_gap0", s_cyc_o, 1'b0);
        nxt();
        s_ack = 1'b1;
        neg();
        chk("ct1_adr", s_adr_o, 30'h00000A00);
        chk("ct1_acks", {m1_ack_o, m0_ack_o}, 2'b01);
        nxt();
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        nxt();
        neg();
        chk("ct_idle_gap", s_cyc_o, 1'b0);
        nxt();
        s_ack = 1'b1;
        neg();
        chk("ct2_adr", s_adr_o, 30'h00000B00);
        chk("ct2_acks", {m1_ack_o, m0_ack_o}, 2'b10);
        nxt();
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h00000A01, 32'h0);
        nxt();
        set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 30'h00000B01, 32'h0);
        nxt();
        s_ack = 1'b1;
        neg();
        chk("ct3_adr", s_adr_o, 30'h00000A01);
        chk("ct3_acks", {m1_ack_o, m0_ack_o}, 2'b01);
        nxt();
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        nxt();
        nxt();
        s_ack = 1'b1;
        neg();
        chk("ct4_adr", s_adr_o, 30'h00000B01);
        chk("ct4_acks", {m1_ack_o, m0_ack_o}, 2'b10);
        nxt();
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        nxt();

        // lock: m1 three write beats while m0 waits
        set_m(1, 1'b1, 1'b1, 1'b1, 4'h3, 30'h20000000, 32'h11110000);
        nxt();
        set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h00000C00, 32'h0);
        s_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_m(1, 1'b1, 1'b1, 1'b1, 4'h3, 30'h20000000 + 30'(k), 32'h11110000 + 32'(k));
            neg();
            chk("lk_we", s_we_o, 1'b1);
            chk("lk_sel", s_sel_o, 4'h3);
            chk("lk_adr", s_adr_o, 30'h20000000 + 30'(k));
            chk("lk_dat", s_dat_o, 32'h11110000 + 32'(k));
            chk("lk_acks", {m1_ack_o, m0_ack_o}, 2'b10);
            nxt();
        end
        set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        neg();
        chk("lk_rel_acks", {m1_ack_o, m0_ack_o}, 2'b00);
        nxt();
        neg();
        chk("lk_idle_acks", {m1_ack_o, m0_ack_o}, 2'b00);
        nxt();
        neg();
        chk("lk_m0_ack", {m1_ack_o, m0_ack_o}, 2'b01);
        chk("lk_m0_we", s_we_o, 1'b0);
        chk("lk_m0_adr", s_adr_o, 30'h00000C00);
        nxt();
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        nxt();

        // stray ack while IDLE
        s_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            neg();
            chk("stray_acks", {m1_ack_o, m0_ack_o}, 2'b00);
            chk("stray_cyc", s_cyc_o, 1'b0);
            nxt();
        end
        s_ack = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h00000D00, 32'h0);
        neg();
        chk("stray_idle", s_cyc_o, 1'b0);
        nxt();
        neg();
        chk("stray_grant", s_cyc_o, 1'b1);

        // asynchronous reset in the middle of a bus cycle
        #1;
        s_ack = 1'b1;
        #1;
        chk("mid_pre_ack", m0_ack_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_s_cyc", s_cyc_o, 1'b0);
        chk("mid_s_stb", s_stb_o, 1'b0);
        chk("mid_s_adr", s_adr_o, 30'h0);
        chk("mid_acks", {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, 4'h0);
        do_reset();

        // watchdog: slave never acks
        set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h00000E00, 32'h0);
        nxt();
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            neg();
            chk("wd_err", m0_err_o, (c == 4) ? 1'b1 : 1'b0);
            chk("wd_cyc", s_cyc_o, (c == 4) ? 1'b0 : 1'b1);
            chk("wd_m1_err", m1_err_o, 1'b0);
            nxt();
        end
        set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        neg();
        chk("wd_after_cyc", s_cyc_o, 1'b0);
        chk("wd_after_err", m0_err_o, 1'b0);
        nxt();
`else
        for (int c = 1; c <= 100; c++) begin
            neg();
            chk("hang_err", {m1_err_o, m0_err_o}, 2'b00);
            chk("hang_cyc", s_cyc_o, 1'b1);
            nxt();
        end
        set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
        nxt();
`endif

        // randomized traffic against the arbitration model
        do_reset();
        m_owner = -1; m_last = 1; m_wait = 0;
        for (int n = 0; n < 2; n++) begin
            gap[n] = 0; act[n] = 1'b0; acked[n] = 1'b0;
            done_cnt[n] = 0; dut_cnt[n] = 0;
        end
        for (int t = 0; t < 500; t++) begin
            for (int n = 0; n < 2; n++) begin
                if (acked[n]) begin
                    set_m(n, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
                    act[n] = 1'b0; acked[n] = 1'b0;
                    gap[n] = $urandom_range(0, 2);
                end else if (!act[n]) begin
                    if (gap[n] > 0) begin
                        gap[n]--;
                    end else if ($urandom_range(0, 1) == 1) begin
                        act[n] = 1'b1;
                        set_m(n, 1'b1, 1'b1, 1'($urandom), 4'($urandom), 30'($urandom), $urandom);
                    end
                end
            end
            s_ack = (m_wait >= 1) ? 1'b1 : 1'($urandom_range(0, 1));
            s_dat = $urandom;
            neg();
            busy = (m_owner >= 0);
            for (int n = 0; n < 2; n++)
                exp_ack[n] = s_ack && busy && (m_owner == n) && mstb[n];
            chk("rnd_s_cyc", s_cyc_o, busy ? mcyc[m_owner] : 1'b0);
            chk("rnd_s_stb", s_stb_o, busy ? mstb[m_owner] : 1'b0);
            chk("rnd_s_we", s_we_o, busy ? mwe[m_owner] : 1'b0);
            chk("rnd_s_sel", s_sel_o, busy ? msel[m_owner] : 4'h0);
            chk("rnd_s_adr", s_adr_o, busy ? madr[m_owner] : 30'h0);
            chk("rnd_s_dat", s_dat_o, busy ? mdat[m_owner] : 32'h0);
            chk("rnd_m0_ack", m0_ack_o, exp_ack[0]);
            chk("rnd_m1_ack", m1_ack_o, exp_ack[1]);
            chk("rnd_err", {m1_err_o, m0_err_o}, 2'b00);
            chk("rnd_m1_dat", m1_dat_o, s_dat);
            if (m0_ack_o === 1'b1) dut_cnt[0]++;
            if (m1_ack_o === 1'b1) dut_cnt[1]++;
            for (int n = 0; n < 2; n++) begin
                if (exp_ack[n]) begin
                    acked[n] = 1'b1;
                    done_cnt[n]++;
                end
            end
            if (busy && mstb[m_owner] && !s_ack) m_wait++;
            else m_wait = 0;
            if (!busy) begin
                if (mcyc != 2'b00) begin
                    if (mcyc == 2'b11) pick = 1 - m_last;
                    else pick = mcyc[1] ? 1 : 0;
                    m_owner = pick;
                    m_last  = pick;
                end
            end else if (!mcyc[m_owner]) begin
                m_owner = -1;
            end
            nxt();
        end
        chk("rnd_m0_count", 32'(dut_cnt[0]), 32'(done_cnt[0]));
        chk("rnd_m1_count", 32'(dut_cnt[1]), 32'(done_cnt[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
